// File: rtl/calc_port_responder.sv
// calc1 per-port golden responder: captures two-cycle requests, queues them in order,
// executes each with a fixed latency and returns exactly one registered response per accepted request.
module calc_port_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned AW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Q_FULL   = CW'(Q_DEPTH);
  localparam logic [3:0]    CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_e;

  cap_state_e    cap_state_q;
  logic [3:0]    cap_cmd_q;
  logic [31:0]   cap_op1_q;

  logic [3:0]    q_cmd_q [Q_DEPTH];
  logic [31:0]   q_op1_q [Q_DEPTH];
  logic [31:0]   q_op2_q [Q_DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic          ex_act_q;
  logic [3:0]    ex_cnt_q;
  logic [3:0]    ex_cmd_q;
  logic [31:0]   ex_op1_q, ex_op2_q;

  logic [1:0]    resp_q;
  logic [31:0]   data_q;
  logic          drop_q;

  logic          push, exec_done, exec_free, pop, bypass, q_wr, q_drop, load;
  logic [3:0]    ld_cmd;
  logic [31:0]   ld_op1, ld_op2;
  logic [32:0]   sum;
  logic [1:0]    res_resp;
  logic [31:0]   res_data;

  // The exec unit is free in its final count cycle, so a new request loads on the same
  // edge that registers the previous response. A full queue is popped before it is pushed.
  always_comb begin
    push      = (cap_state_q == CAP_OP2);
    exec_done = ex_act_q && (ex_cnt_q == 4'd1);
    exec_free = !ex_act_q || exec_done;
    pop       = exec_free && (count_q != '0);
    bypass    = exec_free && (count_q == '0) && push;
    q_wr      = push && !bypass && ((count_q != Q_FULL) || pop);
    q_drop    = push && !bypass && (count_q == Q_FULL) && !pop;
    load      = pop || bypass;
    count_d   = count_q + CW'(q_wr) - CW'(pop);
    if (bypass) begin
      ld_cmd = cap_cmd_q;
      ld_op1 = cap_op1_q;
      ld_op2 = req_data_in;
    end else begin
      ld_cmd = q_cmd_q[head_q];
      ld_op1 = q_op1_q[head_q];
      ld_op2 = q_op2_q[head_q];
    end
  end

  assign sum = {1'b0, ex_op1_q} + {1'b0, ex_op2_q};

  always_comb begin
    res_resp = 2'd2;
    res_data = '0;
    case (ex_cmd_q)
      4'd1: begin
        if (!sum[32]) begin
          res_resp = 2'd1;
          res_data = sum[31:0];
        end
      end
      4'd2: begin
        if (ex_op2_q <= ex_op1_q) begin
          res_resp = 2'd1;
          res_data = ex_op1_q - ex_op2_q;
        end
      end
      4'd5: begin
        res_resp = 2'd1;
        res_data = ex_op1_q << ex_op2_q[4:0];
      end
      4'd6: begin
        res_resp = 2'd1;
        res_data = ex_op1_q >> ex_op2_q[4:0];
      end
      default: begin
        res_resp = 2'd2;
        res_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (q_wr) begin
      q_cmd_q[tail_q] <= cap_cmd_q;
      q_op1_q[tail_q] <= cap_op1_q;
      q_op2_q[tail_q] <= req_data_in;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap_state_q <= CAP_IDLE;
      cap_cmd_q   <= '0;
      cap_op1_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ex_act_q    <= 1'b0;
      ex_cnt_q    <= '0;
      ex_cmd_q    <= '0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      resp_q      <= '0;
      data_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      case (cap_state_q)
        CAP_IDLE: begin
          if (req_cmd_in != '0) begin
            cap_cmd_q   <= req_cmd_in;
            cap_op1_q   <= req_data_in;
            cap_state_q <= CAP_OP2;
          end
        end
        CAP_OP2:  cap_state_q <= CAP_IDLE;
        default:  cap_state_q <= CAP_IDLE;
      endcase

      if (q_wr) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;

      if (load) begin
        ex_act_q <= 1'b1;
        ex_cnt_q <= CNT_LOAD;
        ex_cmd_q <= ld_cmd;
        ex_op1_q <= ld_op1;
        ex_op2_q <= ld_op2;
      end else if (exec_done) begin
        ex_act_q <= 1'b0;
      end else if (ex_act_q) begin
        ex_cnt_q <= ex_cnt_q - 4'd1;
      end

      if (exec_done) begin
        resp_q <= res_resp;
        data_q <= res_data;
      end else begin
        resp_q <= '0;
        data_q <= '0;
      end

      if (q_drop || (push && (req_cmd_in != '0))) drop_q <= 1'b1;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign busy     = (count_q != '0) || ex_act_q || (cap_state_q == CAP_OP2);
  assign drop_err = drop_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder: two instances (LATENCY 3 and 11) share stimulus and are
// compared every cycle against a queue-based request/response model, plus literal spot checks.
module tb_calc_port_responder;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd_in;
  logic [31:0] din;
  logic [1:0]  resp_o [2];
  logic [31:0] data_o [2];
  logic        busy_o [2];
  logic        drop_o [2];

  always #5 clk = ~clk;

  calc_port_responder #(.LATENCY(3), .Q_DEPTH(QD)) u_l3 (
    .c_clk(clk), .reset(rst), .req_cmd_in(cmd_in), .req_data_in(din),
    .out_resp(resp_o[0]), .out_data(data_o[0]), .busy(busy_o[0]), .drop_err(drop_o[0])
  );

  calc_port_responder #(.LATENCY(11), .Q_DEPTH(QD)) u_l11 (
    .c_clk(clk), .reset(rst), .req_cmd_in(cmd_in), .req_data_in(din),
    .out_resp(resp_o[1]), .out_data(data_o[1]), .busy(busy_o[1]), .drop_err(drop_o[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : 11;
  endfunction

  function automatic void chk(input string nm, input int inst, input logic [33:0] got,
                              input logic [33:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s L%0d cycle %0d: got %h, expected %h", nm, lat_of(inst), cyc, got, exp);
  endfunction

  // Response {resp, data} straight from the arithmetic rules.
  function automatic logic [33:0] calc(input logic [3:0] c, input logic [31:0] a,
                                       input logic [31:0] b);
    longint unsigned s;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, 32'(s)};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5:    return {2'd1, a << (b % 32)};
      4'd6:    return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // Model: pending capture, a FIFO of precomputed responses, one in-flight response with its due cycle.
  bit          mpend = 1'b0;
  logic [3:0]  mcmd;
  logic [31:0] mop1;
  logic [33:0] mbuf [2][64];
  int          mhd [2];
  int          mtl [2];
  bit          infl [2];
  int          due [2];
  logic [33:0] ival [2];
  logic [1:0]  e_resp [2];
  logic [31:0] e_data [2];
  logic        e_busy [2];
  logic        e_drop [2];

  always @(posedge clk) begin
    bit          push, viol, byp;
    logic [33:0] pent;
    push = mpend;
    pent = calc(mcmd, mop1, din);
    viol = mpend && (cmd_in != 4'd0);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        infl[i] = 1'b0; mhd[i] = 0; mtl[i] = 0;
        e_resp[i] = '0; e_data[i] = '0; e_drop[i] = 1'b0;
      end else begin
        e_resp[i] = '0;
        e_data[i] = '0;
        if (infl[i] && due[i] == cyc + 1) begin
          {e_resp[i], e_data[i]} = ival[i];
          infl[i] = 1'b0;
        end
        byp = 1'b0;
        if (!infl[i]) begin
          if (mtl[i] != mhd[i]) begin
            ival[i] = mbuf[i][mhd[i] % 64];
            mhd[i]++;
            infl[i] = 1'b1;
            due[i]  = cyc + lat_of(i);
          end else if (push) begin
            ival[i] = pent;
            infl[i] = 1'b1;
            due[i]  = cyc + lat_of(i);
            byp     = 1'b1;
          end
        end
        if (push && !byp) begin
          if (mtl[i] - mhd[i] < QD) begin
            mbuf[i][mtl[i] % 64] = pent;
            mtl[i]++;
          end else begin
            e_drop[i] = 1'b1;
          end
        end
        if (viol) e_drop[i] = 1'b1;
      end
    end
    if (rst || mpend) mpend = 1'b0;
    else if (cmd_in != 4'd0) begin
      mpend = 1'b1;
      mcmd  = cmd_in;
      mop1  = din;
    end
    for (int i = 0; i < 2; i++)
      e_busy[i] = !rst && ((mtl[i] != mhd[i]) || infl[i] || mpend);
    cyc++;
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("resp", i, 34'(resp_o[i]), 34'(e_resp[i]));
        chk("data", i, 34'(data_o[i]), 34'(e_data[i]));
        chk("busy", i, 34'(busy_o[i]), 34'(e_busy[i]));
        chk("drop_err", i, 34'(drop_o[i]), 34'(e_drop[i]));
      end
    end
  end

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
      2:       return $urandom_range(0, 40);
      default: return 32'h8000_0000 | $urandom_range(0, 40);
    endcase
  endfunction

  function automatic logic [3:0] rnd_cmd();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(1, 15));
    case ($urandom_range(0, 3))
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd5;
      default: return 4'd6;
    endcase
  endfunction

  // Request with operand2 in cycle T; L3 response must sit in T+3 only.
  task automatic directed(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    @(negedge clk); cmd_in = c;    din = a;
    @(negedge clk); cmd_in = 4'd0; din = b;
    repeat (3) begin
      @(negedge clk); din = $urandom;
    end
    chk({nm, "_rsp"}, 0, {resp_o[0], data_o[0]}, {er, ed});
    chk({nm, "_model"}, 0, {e_resp[0], e_data[0]}, {er, ed});
    @(negedge clk);
    chk({nm, "_after"}, 0, {resp_o[0], data_o[0]}, 34'd0);
  endtask

  initial begin
    logic [33:0] got [$];
    int nz;
    rst = 1'b1; cmd_in = 4'($urandom); din = $urandom;
    repeat (7) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("rst_out", i, {resp_o[i], data_o[i]}, 34'd0);
        chk("rst_flags", i, 34'({busy_o[i], drop_o[i]}), 34'd0);
      end
      cmd_in = 4'($urandom); din = $urandom;
    end
    rst = 1'b0; cmd_in = 4'd0; din = '0;

    directed("add_1_2",   4'd1, 32'd1,          32'd2,          2'd1, 32'd3);
    directed("add_ovf",   4'd1, 32'hFFFF_FFFF,  32'd1,          2'd2, 32'd0);
    directed("sub_5_6",   4'd2, 32'd5,          32'd6,          2'd2, 32'd0);
    directed("sub_6_5",   4'd2, 32'd6,          32'd5,          2'd1, 32'd1);
    directed("shl_wrap",  4'd5, 32'd1,          32'h21,         2'd1, 32'd2);
    directed("shr_31",    4'd6, 32'h8000_0000,  32'd31,         2'd1, 32'd1);
    directed("cmd3",      4'd3, 32'd9,          32'd9,          2'd2, 32'd0);
    chk("directed_nodrop", 0, 34'(drop_o[0]), 34'd0);

    // Eight back-to-back adds into the LATENCY 11 port: six fit, the 7th and 8th find it full.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      begin
        for (int n = 1; n <= 8; n++) begin
          cmd_in = 4'd1;  din = 32'(n);
          @(negedge clk);
          cmd_in = 4'd0;  din = 32'(n);
          @(negedge clk);
        end
      end
      begin
        repeat (100) begin
          @(negedge clk);
          if (resp_o[1] != 2'd0) got.push_back({resp_o[1], data_o[1]});
        end
      end
    join
    chk("burst_count", 1, 34'(got.size()), 34'd6);
    for (int k = 0; k < 6; k++)
      chk("burst_rsp", 1, (k < got.size()) ? got[k] : 34'h3_FFFF_FFFF, {2'd1, 32'(2 * (k + 1))});
    chk("burst_drop", 1, 34'(drop_o[1]), 34'd1);

    // Two requests queued, then reset before the LATENCY 11 port answers either.
    @(negedge clk); cmd_in = 4'd1; din = 32'd10;
    @(negedge clk); cmd_in = 4'd0; din = 32'd20;
    @(negedge clk); cmd_in = 4'd2; din = 32'd50;
    @(negedge clk); cmd_in = 4'd0; din = 32'd7;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, 34'(busy_o[0]), 34'd0);
    chk("abort_busy", 1, 34'(busy_o[1]), 34'd0);
    rst = 1'b0;
    nz = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_o[1] != 2'd0) nz++;
    end
    chk("abort_resp", 1, 34'(nz), 34'd0);

    // Randomized traffic: gaps, edge operands, occasional protocol violations and resets.
    for (int r = 0; r < 400; r++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); cmd_in = 4'd0; din = $urandom;
      end
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk); rst = 1'b1; cmd_in = 4'($urandom); din = $urandom;
        @(negedge clk); rst = 1'b0; cmd_in = 4'd0;
      end
      @(negedge clk); cmd_in = rnd_cmd(); din = rnd_data();
      @(negedge clk);
      cmd_in = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      din = rnd_data();
    end
    @(negedge clk); cmd_in = 4'd0;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
